// File: rtl/samp_rand_buf.sv
// Repacks 64-bit PRNG words into 80-bit random blocks for the base sampler.
// A 24-byte FIFO-by-shift buffer; the oldest byte always sits in buf bits [7:0].
module samp_rand_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        prng_valid,
    input  logic [63:0] prng_data,
    output logic        prng_ready,
    output logic        rand_valid,
    output logic [79:0] random_bytes,
    input  logic        rand_pop,
    output logic [15:0] sample_cnt,
    output logic        err_underflow
);

    logic [191:0] data_buf, shifted_buf, ins_word, next_buf;
    logic [4:0]   cnt, base_cnt, next_cnt;
    logic         push, pop;

    assign rand_valid   = (cnt >= 5'd10);
    assign random_bytes = data_buf[79:0];
    assign prng_ready   = (cnt <= 5'd16) & ~flush;
    assign push         = prng_valid & prng_ready;
    assign pop          = rand_pop & rand_valid & ~flush;

    // Bytes above cnt are always zero, so the new word can be OR-ed in place.
    always_comb begin
        shifted_buf = data_buf;
        base_cnt    = cnt;
        if (pop) begin
            shifted_buf = {80'd0, data_buf[191:80]};
            base_cnt    = cnt - 5'd10;
        end
        ins_word = {128'd0, prng_data} << {base_cnt, 3'b000};
        next_buf = shifted_buf;
        next_cnt = base_cnt;
        if (push) begin
            next_buf = shifted_buf | ins_word;
            next_cnt = base_cnt + 5'd8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_buf      <= '0;
            cnt           <= '0;
            sample_cnt    <= '0;
            err_underflow <= 1'b0;
        end else if (flush) begin
            data_buf      <= '0;
            cnt           <= '0;
            sample_cnt    <= '0;
            err_underflow <= 1'b0;
        end else begin
            data_buf <= next_buf;
            cnt      <= next_cnt;
            if (pop)
                sample_cnt <= sample_cnt + 16'd1;
            if (rand_pop && !rand_valid)
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_samp_rand_buf.sv
// Bench for samp_rand_buf: byte-queue scoreboard, directed steps then a throttled random stream.
module tb_samp_rand_buf;

    logic        clk = 1'b0;
    logic        rst_n, flush, prng_valid, rand_pop;
    logic [63:0] prng_data;
    logic        prng_ready, rand_valid, err_underflow;
    logic [79:0] random_bytes;
    logic [15:0] sample_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  sb[$];       // bytes accepted and not yet popped, oldest first
    logic [15:0] exp_sc = 0;
    logic        exp_err = 0;
    int          words = 0;

    always #5 clk = ~clk;

    samp_rand_buf dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .prng_valid(prng_valid), .prng_data(prng_data), .prng_ready(prng_ready),
        .rand_valid(rand_valid), .random_bytes(random_bytes), .rand_pop(rand_pop),
        .sample_cnt(sample_cnt), .err_underflow(err_underflow)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] exp_block();
        logic [79:0] b = '0;
        for (int i = 0; i < 10; i++)
            if (i < sb.size()) b[8*i +: 8] = sb[i];
        return b;
    endfunction

    task automatic check_outputs();
        check("prng_ready", 80'(prng_ready), 80'(!flush && sb.size() <= 16));
        check("rand_valid", 80'(rand_valid), 80'(sb.size() >= 10));
        check("random_bytes", random_bytes, exp_block());
        check("sample_cnt", 80'(sample_cnt), 80'(exp_sc));
        check("err_underflow", 80'(err_underflow), 80'(exp_err));
    endtask

    // Drive one cycle, check outputs mid-cycle, clock, then update the scoreboard.
    task automatic cycle(input logic f, input logic v, input logic [63:0] d, input logic p);
        logic do_push, do_pop;
        flush = f; prng_valid = v; prng_data = d; rand_pop = p;
        #1;
        check_outputs();
        do_push = !f && v && sb.size() <= 16;
        do_pop  = !f && p && sb.size() >= 10;
        @(posedge clk); #1;
        if (f) begin
            sb.delete(); exp_sc = 0; exp_err = 0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < 10; i++) void'(sb.pop_front());
                exp_sc++;
            end else if (p) exp_err = 1'b1;
            if (do_push) begin
                for (int i = 0; i < 8; i++) sb.push_back(d[8*i +: 8]);
                words++;
            end
        end
        flush = 0; prng_valid = 0; rand_pop = 0;
    endtask

    task automatic async_reset();
        flush = 0; prng_valid = 0; rand_pop = 0;
        rst_n = 1'b0;
        sb.delete(); exp_sc = 0; exp_err = 0;
        #1;
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        bit did_reset;
        rst_n = 1'b0; flush = 0; prng_valid = 0; prng_data = '0; rand_pop = 0;
        #12;
        check_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two words raise rand_valid, oldest byte in [7:0]
        cycle(0, 1, 64'h0706050403020100, 0);
        check("valid_after_w0", 80'(rand_valid), 80'd0);
        cycle(0, 1, 64'h0F0E0D0C0B0A0908, 0);
        #1;
        check("block0", random_bytes, 80'h09080706050403020100);

        // Push and pop in the same cycle
        cycle(0, 1, 64'h1716151413121110, 1);
        #1;
        check("block1", random_bytes, 80'h131211100F0E0D0C0B0A);
        check("sc_after_pop", 80'(sample_cnt), 80'd1);

        // Fill to 24 bytes with valid held; the 4th word must be refused
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 64'hA0A1A2A3A4A5A6A7 + 64'(i), 0);
        #1;
        check("ready_at_24", 80'(prng_ready), 80'd0);
        cycle(0, 1, 64'hDEADBEEFDEADBEEF, 1);
        check("ready_after_pop", 80'(prng_ready), 80'd1);
        cycle(0, 0, '0, 1);
        check("valid_at_4", 80'(rand_valid), 80'd0);

        // Underflow from empty, cleared by flush
        cycle(1, 0, '0, 0);
        cycle(0, 0, '0, 1);
        check("err_set", 80'(err_underflow), 80'd1);
        check("sc_no_change", 80'(sample_cnt), 80'd0);
        cycle(1, 0, '0, 0);
        check("err_cleared", 80'(err_underflow), 80'd0);

        // Reach 12 bytes, then flush with push and pop
        for (int i = 0; i < 3; i++) cycle(0, 1, 64'h0102030405060708 * 64'(i + 3), 0);
        cycle(0, 0, '0, 1);
        cycle(0, 1, 64'h1122334455667788, 1);
        flush = 1; prng_valid = 1; rand_pop = 1; #1;
        check("ready_in_flush", 80'(prng_ready), 80'd0);
        check("valid_at_12", 80'(rand_valid), 80'd1);
        cycle(1, 1, 64'hCAFECAFECAFECAFE, 1);
        #1;
        check("flush_bytes", random_bytes, 80'd0);
        check("flush_sc", 80'(sample_cnt), 80'd0);
        check("flush_valid", 80'(rand_valid), 80'd0);

        // Random throttled stream with one mid-run reset
        words = 0; cyc = 0; did_reset = 0;
        while (words < 10000 && cyc < 80000) begin
            if (!did_reset && words >= 5000) begin
                async_reset();
                did_reset = 1;
            end
            cycle(0, 1'($urandom_range(0, 9) < 6), {$urandom, $urandom},
                  1'($urandom_range(0, 1)));
            cyc++;
        end
        check("stream_done", 80'(words >= 10000), 80'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
